video_sync_normalizer: RTL and testbench
========================================

Name: video_sync_normalizer

Overview:
Upstream conditioning stage for the scandoubler, placed between a core's raw video output and the scandoubler inputs. It detects HSync/VSync polarity per line/frame and emits active-high syncs. It re-times VSync so each VSync edge coincides with an HSync leading edge, and forces RGB to zero during blanking. Output is one clean, ce_pix-aligned bundle, so the downstream line/position counters always see consistent edges.

Parameters:
DW, 8, colour component width in bits (4 for half-depth builds)
HCNT_W, 12, width of the horizontal polarity counters (pixels per line)
VCNT_W, 11, width of the vertical polarity counters (lines per frame)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
ce_pix  in  1  pixel clock enable; state advances only when high
r_in/g_in/b_in  in  DW each  raw colour
hs_in  in  1  raw HSync, unknown polarity
vs_in  in  1  raw VSync, unknown polarity
hb_in  in  1  horizontal blank, active-high
vb_in  in  1  vertical blank, active-high
r_out/g_out/b_out  out  DW each  colour, zero in blanking
hs_out  out  1  HSync, active-high
vs_out  out  1  VSync, active-high, HS-aligned
hb_out  out  1  delayed hb_in
vb_out  out  1  delayed vb_in
de_out  out  1  ~(hb_out|vb_out)
hs_pol  out  1  1 = raw HSync detected active-low
vs_pol  out  1  1 = raw VSync detected active-low

Behaviour:
- Reset (async, active-high): every output = 0; all counters = 0; hs_pol = vs_pol = 0; edge-detect history regs = 0.
- Cycles with ce_pix = 0: no state or output changes.
- Pixel pipeline: 1 ce latency. On ce, hb_out <= hb_in and vb_out <= vb_in. r/g/b_out <= (hb_in|vb_in) ? 0 : input.
- hs_n = hs_in ^ hs_pol (combinational). hs_out <= hs_n on ce, so hs_out has the same 1-ce latency as colour.
- HS polarity measurement:
  - Raw level counters hi_cnt/lo_cnt increment on ce for hs_in = 1/0. They saturate at all-ones and do not wrap.
  - A line boundary is a ce where hs_in = 1 and the previous hs_in = 0 (raw rising edge).
  - At the boundary: hi_cnt > lo_cnt sets hs_pol <= 1; hi_cnt < lo_cnt sets hs_pol <= 0; equal counts leave hs_pol unchanged. Then hi_cnt <= 1 (current sample is high) and lo_cnt <= 0.
- VS polarity measurement:
  - vhi_cnt/vlo_cnt increment once per line, on each ce where the previous hs_n = 0 and the current hs_n = 1 (normalized HS leading edge). The level counted is vs_in at that ce.
  - Frame boundary is a raw vs_in rising edge on any ce. At the frame boundary, vs_pol updates with the same rule and tie handling as hs_pol, and both counters clear to 0.
  - If a frame boundary and a line tick fall on the same ce, the boundary wins: decide first, then clear. That tick is not counted.
  - Counters saturate and do not wrap.
- VS alignment: vs_out <= vs_in ^ vs_pol, updated only on the normalized-HS leading-edge ce; otherwise held. vs_out therefore changes on the same ce that hs_out rises.
- Polarity switches take effect at the boundary ce. A one-line (HS) or one-frame (VS) glitch is acceptable and must not lock up.
- Reset mid-frame: detection restarts from hs_pol = vs_pol = 0. Correct polarity is reached after one complete line (HS) or one complete frame (VS).

Decomposition:
- Shared package video_pkg: typedef rgb_t (three DW fields) and localparams HCNT_W_DEF = 12 and VCNT_W_DEF = 11.
- One sub-module: sync_pol_detect. Inputs: clk_sys, reset, tick_en, level, boundary. Output: pol. Parameter: counter width. Instantiate it twice:
  - HS: tick_en = ce_pix, boundary = raw hs rise.
  - VS: tick_en = HS leading-edge ce, boundary = raw vs rise.

Test Plan:
- Active-high raw HS (line 100 ce, hs_in high 8) → hs_pol = 0 after first line; hs_out high 8 ce/line, 1 ce after hs_in.
- Active-low raw HS (hs_in low 8 of 100) → hs_pol = 1 from 2nd boundary; hs_out high exactly 8 ce/line.
- Active-low VS (frame 262 lines, vs_in low 3) → vs_pol = 1 after first frame; vs_out high 3 lines and rises on the same ce as hs_out rises, even when vs_in edge is offset 37 ce into the line.
- Blanking: hb_in = 1 with r_in = 8'hFF → r_out = 0, de_out = 0, 1 ce later; hb_in = 0 → r_out = 8'hFF, de_out = 1.
- ce_pix toggled every 4th clk_sys → outputs change only on ce cycles. Tie case (hi = lo = 50) → hs_pol unchanged. 5000-ce line → counter saturates at 4095 with no wrap, and polarity is still decided.
- Assert reset mid-line while hs_pol = 1 → all outputs 0 and hs_pol = 0 immediately (async); after 2 lines, hs_pol = 1 again.

Source files
------------

// File: rtl/video_sync_normalizer_pkg.sv
// Shared types and defaults for the video conditioning path.
// Holds the pixel struct, counter-width defaults and the polarity vote helper.
package video_pkg;

  localparam int DW_DEF     = 8;
  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;

  typedef struct packed {
    logic [DW_DEF-1:0] r;
    logic [DW_DEF-1:0] g;
    logic [DW_DEF-1:0] b;
  } rgb_t;

  // The level that dominated the last period is the idle level.
  // Mostly-high therefore means active-low. A tie keeps the current verdict.
  function automatic logic pol_decide(input logic cur, input logic hi_more, input logic lo_more);
    if (hi_more) return 1'b1;
    if (lo_more) return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/video_sync_normalizer_sync_pol_detect.sv
// Sync polarity detector: counts high/low samples per period (saturating)
// and votes the polarity at each period boundary.
module sync_pol_detect
  import video_pkg::*;
#(
  parameter int CW        = HCNT_W_DEF,
  parameter bit KEEP_TICK = 1'b0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic tick_en,
  input  logic level,
  input  logic boundary,
  output logic pol
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] lo_cnt;
  logic          seed_hi;
  logic          seed_lo;

  // KEEP_TICK lets the boundary sample open the new period instead of being dropped.
  assign seed_hi = KEEP_TICK & tick_en & level;
  assign seed_lo = KEEP_TICK & tick_en & ~level;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      pol    <= 1'b0;
    end else if (boundary) begin
      pol    <= pol_decide(pol, hi_cnt > lo_cnt, hi_cnt < lo_cnt);
      hi_cnt <= {{(CW-1){1'b0}}, seed_hi};
      lo_cnt <= {{(CW-1){1'b0}}, seed_lo};
    end else if (tick_en) begin
      if (level && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_ONE;
      if (!level && (lo_cnt != CNT_MAX)) lo_cnt <= lo_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/video_sync_normalizer.sv
// Normalizes raw core video for the scandoubler: active-high syncs,
// VSync re-timed to HSync leading edges, and colour blanked, all 1 ce late.
module video_sync_normalizer
  import video_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int HCNT_W = HCNT_W_DEF,
  parameter int VCNT_W = VCNT_W_DEF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          hb_in,
  input  logic          vb_in,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hb_out,
  output logic          vb_out,
  output logic          de_out,
  output logic          hs_pol,
  output logic          vs_pol
);

  logic hs_prev;
  logic vs_prev;
  logic hs_n;
  logic hs_rise;
  logic vs_rise;
  logic hs_lead;
  logic blank;

  // hs_out holds the previous normalized HS, so it doubles as edge history.
  assign hs_n    = hs_in ^ hs_pol;
  assign hs_rise = ce_pix & hs_in & ~hs_prev;
  assign vs_rise = ce_pix & vs_in & ~vs_prev;
  assign hs_lead = ce_pix & hs_n & ~hs_out;
  assign blank   = hb_in | vb_in;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      r_out   <= '0;
      g_out   <= '0;
      b_out   <= '0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      hb_out  <= 1'b0;
      vb_out  <= 1'b0;
      de_out  <= 1'b0;
    end else if (ce_pix) begin
      hs_prev <= hs_in;
      vs_prev <= vs_in;
      r_out   <= blank ? '0 : r_in;
      g_out   <= blank ? '0 : g_in;
      b_out   <= blank ? '0 : b_in;
      hb_out  <= hb_in;
      vb_out  <= vb_in;
      de_out  <= ~blank;
      hs_out  <= hs_n;
      if (hs_lead) vs_out <= vs_in ^ vs_pol;
    end
  end

  sync_pol_detect #(.CW(HCNT_W), .KEEP_TICK(1'b1)) u_hs_pol (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .tick_en  (ce_pix),
    .level    (hs_in),
    .boundary (hs_rise),
    .pol      (hs_pol)
  );

  // Line ticks count VS level once per line; a coincident frame boundary drops the tick.
  sync_pol_detect #(.CW(VCNT_W), .KEEP_TICK(1'b0)) u_vs_pol (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .tick_en  (hs_lead),
    .level    (vs_in),
    .boundary (vs_rise),
    .pol      (vs_pol)
  );

endmodule

// File: tb/tb_video_sync_normalizer.sv
// Bench for video_sync_normalizer: randomized pixels against a behavioural
// model, plus literal checks on polarity, widths, alignment and reset.
module tb_video_sync_normalizer;

  localparam int DW   = 8;
  localparam int HMAX = 4095;
  localparam int VMAX = 2047;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ce_pix;
  logic [DW-1:0] r_in, g_in, b_in;
  logic          hs_in, vs_in, hb_in, vb_in;
  logic [DW-1:0] r_out, g_out, b_out;
  logic          hs_out, vs_out, hb_out, vb_out, de_out, hs_pol, vs_pol;

  video_sync_normalizer #(.DW(DW), .HCNT_W(12), .VCNT_W(11)) dut (
    .clk_sys (clk_sys), .reset (reset), .ce_pix (ce_pix),
    .r_in (r_in), .g_in (g_in), .b_in (b_in),
    .hs_in (hs_in), .vs_in (vs_in), .hb_in (hb_in), .vb_in (vb_in),
    .r_out (r_out), .g_out (g_out), .b_out (b_out),
    .hs_out (hs_out), .vs_out (vs_out), .hb_out (hb_out), .vb_out (vb_out),
    .de_out (de_out), .hs_pol (hs_pol), .vs_pol (vs_pol)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int ce_div   = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_hi, m_lo, m_vhi, m_vlo;
  bit            m_hs_pol, m_vs_pol, m_hs_prev, m_vs_prev, m_hsn_prev;
  logic [DW-1:0] e_r, e_g, e_b;
  bit            e_hs, e_vs, e_hb, e_vb, e_de;

  function automatic bit vote(input bit cur, input int hi, input int lo);
    if (hi > lo) return 1'b1;
    if (hi < lo) return 1'b0;
    return cur;
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  function automatic void model_reset();
    m_hi = 0; m_lo = 0; m_vhi = 0; m_vlo = 0;
    m_hs_pol = 0; m_vs_pol = 0; m_hs_prev = 0; m_vs_prev = 0; m_hsn_prev = 0;
    e_r = '0; e_g = '0; e_b = '0;
    e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_de = 0;
  endfunction

  // One pixel: line/frame statistics are gathered per period and voted at its end.
  function automatic void model_pixel();
    bit hs_n, lead, blank;
    hs_n  = hs_in ^ m_hs_pol;
    lead  = hs_n && !m_hsn_prev;
    blank = hb_in || vb_in;
    e_r = blank ? '0 : r_in;
    e_g = blank ? '0 : g_in;
    e_b = blank ? '0 : b_in;
    e_hb = hb_in; e_vb = vb_in; e_de = !blank; e_hs = hs_n;
    if (lead) e_vs = vs_in ^ m_vs_pol;
    if (vs_in && !m_vs_prev) begin
      m_vs_pol = vote(m_vs_pol, m_vhi, m_vlo);
      m_vhi = 0; m_vlo = 0;
    end else if (lead) begin
      if (vs_in) m_vhi = sat_inc(m_vhi, VMAX);
      else       m_vlo = sat_inc(m_vlo, VMAX);
    end
    if (hs_in && !m_hs_prev) begin
      m_hs_pol = vote(m_hs_pol, m_hi, m_lo);
      m_hi = 1; m_lo = 0;
    end else if (hs_in) m_hi = sat_inc(m_hi, HMAX);
    else                m_lo = sat_inc(m_lo, HMAX);
    m_hs_prev = hs_in; m_vs_prev = vs_in; m_hsn_prev = hs_n;
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    if (reset) model_reset();
    else if (ce_pix) model_pixel();
  end

  // ---------------- compare process + observations ----------------
  bit ce_q;
  bit hs_out_prev, vs_out_prev;
  int hs_hi_cnt, vs_lines, align_err;

  always @(posedge clk_sys) ce_q <= ce_pix;

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("outputs", 32'({r_out, g_out, b_out, hs_out, vs_out, hb_out, vb_out, de_out}),
                       32'({e_r, e_g, e_b, e_hs, e_vs, e_hb, e_vb, e_de}));
      check("pols", 32'({hs_pol, vs_pol}), 32'({m_hs_pol, m_vs_pol}));
      if (ce_q && hs_out) hs_hi_cnt++;
      if ((vs_out != vs_out_prev) && !(hs_out && !hs_out_prev)) align_err++;
      if (hs_out && !hs_out_prev && vs_out) vs_lines++;
    end
    hs_out_prev = hs_out;
    vs_out_prev = vs_out;
  end

  // ---------------- driver tasks ----------------
  int vb_g = 0;

  task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb,
                     input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
    for (int k = 0; k < ce_div; k++) begin
      @(posedge clk_sys);
      #2;
      if (k == ce_div - 1) begin
        ce_pix = 1'b1;
        hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
        r_in = r; g_in = g; b_in = b;
      end else begin
        ce_pix = 1'b0;
        hs_in = 1'($urandom_range(0, 1)); vs_in = 1'($urandom_range(0, 1));
        hb_in = 1'($urandom_range(0, 1)); vb_in = 1'($urandom_range(0, 1));
        r_in = 8'($urandom_range(0, 255)); g_in = 8'($urandom_range(0, 255));
        b_in = 8'($urandom_range(0, 255));
      end
    end
  endtask

  // HS active for w pixels; low_first puts the low phase first (active-low HS).
  task automatic line(input int len, input int w, input bit low_first);
    for (int i = 0; i < len; i++) begin
      pix(low_first ? (i >= w) : (i < w), 1'b0, i < 10, vb_g[0],
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
  endtask

  // Active-high HS (8 ce); active-low VS pulse 3 lines long starting off ce into the frame.
  task automatic frame(input int nl, input int len, input int off);
    int p;
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < len; i++) begin
        p = l * len + i;
        pix(i < 8, !((p >= off) && (p < off + 3 * len)), i < 10, l < 5,
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
    end
  endtask

  task automatic pulse_reset();
    ce_pix = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk_sys);
    #2 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; ce_pix = 1'b0;
    hs_in = 0; vs_in = 0; hb_in = 0; vb_in = 0;
    r_in = '0; g_in = '0; b_in = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #2;
    check("reset_outputs", 32'({r_out, g_out, b_out, hs_out, vs_out, hb_out, vb_out, de_out}), 32'd0);
    check("reset_pols", 32'({hs_pol, vs_pol}), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // active-high HS
    repeat (2) line(100, 8, 1'b0);
    hs_hi_cnt = 0;
    repeat (3) line(100, 8, 1'b0);
    check("hs_pol_active_high", 32'(hs_pol), 32'd0);
    check("hs_width_active_high", 32'(hs_hi_cnt), 32'd24);

    // blanking
    pix(0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF);
    pix(0, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    check("blank_r", 32'(r_out), 32'h00);
    check("blank_de", 32'(de_out), 32'd0);
    pix(0, 0, 0, 0, 8'h12, 8'h34, 8'h56);
    check("active_r", 32'(r_out), 32'hFF);
    check("active_de", 32'(de_out), 32'd1);

    // active-low HS
    repeat (2) line(100, 8, 1'b1);
    hs_hi_cnt = 0;
    repeat (3) line(100, 8, 1'b1);
    check("hs_pol_active_low", 32'(hs_pol), 32'd1);
    check("hs_width_active_low", 32'(hs_hi_cnt), 32'd24);

    // sparse ce
    ce_div = 4;
    repeat (2) line(100, 8, 1'b1);
    ce_div = 1;

    // tie keeps polarity
    repeat (2) line(100, 50, 1'b1);
    check("hs_pol_tie", 32'(hs_pol), 32'd1);

    // saturation: 4500 low samples must clamp to 4095, beating 560 high
    line(600, 40, 1'b1);
    check("hs_pol_pre_sat", 32'(hs_pol), 32'd1);
    line(5000, 4500, 1'b1);
    check("hs_pol_saturated", 32'(hs_pol), 32'd0);

    // reset mid-line with hs_pol = 1
    repeat (2) line(100, 8, 1'b1);
    check("hs_pol_before_reset", 32'(hs_pol), 32'd1);
    line(30, 8, 1'b1);
    @(negedge clk_sys);
    #1 reset = 1'b1; ce_pix = 1'b0;
    #1;
    check("async_reset_outputs", 32'({r_out, g_out, b_out, hs_out, vs_out, hb_out, vb_out, de_out}), 32'd0);
    check("async_reset_hs_pol", 32'(hs_pol), 32'd0);
    repeat (2) @(posedge clk_sys);
    #2 reset = 1'b0;
    repeat (2) line(100, 8, 1'b1);
    check("hs_pol_recovered", 32'(hs_pol), 32'd1);

    // active-low VS, edges offset 37 ce into the line
    pulse_reset();
    check("vs_pol_start", 32'(vs_pol), 32'd0);
    repeat (2) frame(262, 40, 37);
    check("vs_pol_active_low", 32'(vs_pol), 32'd1);
    align_err = 0;
    vs_lines  = 0;
    frame(262, 40, 37);
    check("vs_high_lines", 32'(vs_lines), 32'd3);
    check("vs_hs_alignment", 32'(align_err), 32'd0);
    check("hs_pol_in_frames", 32'(hs_pol), 32'd0);

    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
